// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus endpoint: packet ID field layout.
package bus_ep_pkg;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

   // Widest packet the ID helper accepts; callers zero-extend narrower packets.
   localparam int PKT_W_MAX = 256;

   // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
   function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_W_MAX-1:0] pkt,
                                              input int pkt_w);
      return pkt[pkt_w-1 -: ID_W];
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
// A read on a full FIFO frees the slot for a same-cycle write; a read on an
// empty FIFO is ignored, so a same-cycle write still lands.
module sync_fifo_fwft #(
   parameter int width = 16,
   parameter int depth = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [width-1:0]         din,
   input  logic                     rd,
   output logic [width-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);
   import bus_ep_pkg::*;

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = PTR_W + 1;

   logic [width-1:0] mem_q [depth];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, empty_q;
   logic             do_wr, do_rd;

   // Qualify requests against current flags and compute next pointers/count.
   always_comb begin
      do_rd    = rd & ~empty_q;
      do_wr    = wr & (~full_q | rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_wr && !do_rd) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!do_wr && do_rd) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Pointer, count and flag registers; flags derive from next count so they
   // are registered with no input-to-flag combinational path.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= (cnt_d == CNT_W'(depth));
         empty_q  <= (cnt_d == '0);
      end
   end

   // Storage array; contents are intentionally not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && do_wr) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = cnt_q;

endmodule

// File: rtl/drvr_fifo_endpoint.sv
// Per-port bus endpoint: TX queue drained by the bus via pndng/pop/D_pop and
// RX queue filled via push/D_push. RX filters by destination ID (own ID or
// broadcast) and counts words lost to a full RX queue.
module drvr_fifo_endpoint #(
   parameter int         width = 16,
   parameter int         depth = 16,
   parameter logic [7:0] my_id = 8'd0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             pndng,
   output logic [width-1:0] D_pop,
   input  logic             pop,
   input  logic             push,
   input  logic [width-1:0] D_push,
   input  logic             wr_en,
   input  logic [width-1:0] wr_data,
   output logic             tx_full,
   input  logic             rd_en,
   output logic [width-1:0] rd_data,
   output logic             rx_empty,
   output logic [15:0]      drop_cnt,
   output logic             tx_err
);
   import bus_ep_pkg::*;

   localparam int CNT_W = $clog2(depth) + 1;

   logic             tx_empty;
   logic             rx_full;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic [ID_W-1:0]  push_id;
   logic             rx_accept, rx_drop;
   logic             tx_err_q, tx_err_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             unused_cnt;

   sync_fifo_fwft #(.width(width), .depth(depth)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en),
      .din   (wr_data),
      .rd    (pop),
      .dout  (D_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo_fwft #(.width(width), .depth(depth)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (rx_accept),
      .din   (D_push),
      .rd    (rd_en),
      .dout  (rd_data),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // Occupancy counts are kept for debug visibility only.
   assign unused_cnt = ^{tx_count, rx_count};

   assign pndng = ~tx_empty;

   // ID filter and drop/error next-state; a full RX with rd_en still accepts.
   always_comb begin
      push_id    = pkt_id(PKT_W_MAX'(D_push), width);
      rx_accept  = push & ((push_id == my_id) | (push_id == BCAST_ID));
      rx_drop    = rx_accept & rx_full & ~rd_en;
      drop_cnt_d = drop_cnt_q;
      if (rx_drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
      tx_err_d   = (wr_en & tx_full & ~pop) | (pop & tx_empty);
   end

   // Registered drop counter and single-cycle TX error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         tx_err_q   <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         tx_err_q   <= tx_err_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_drvr_fifo_endpoint.sv
// Bench for drvr_fifo_endpoint: directed scenarios plus randomized traffic
// compared with a queue-based reference model, and a small 8-port bus.
module tb_drvr_fifo_endpoint;

   localparam int         W     = 16;
   localparam int         D     = 16;
   localparam logic [7:0] MY_ID = 8'd3;
   localparam int         DRVS  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, pop, push, wr_en, rd_en;
   logic [W-1:0]  d_push, wr_data;
   logic          pndng, tx_full, rx_empty, tx_err;
   logic [W-1:0]  d_pop, rd_data;
   logic [15:0]   drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_tx[$];
   logic [W-1:0] m_rx[$];
   int           m_drop;
   bit           m_err;

   drvr_fifo_endpoint #(.width(W), .depth(D), .my_id(MY_ID)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
      .push(push), .D_push(d_push), .wr_en(wr_en), .wr_data(wr_data),
      .tx_full(tx_full), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
      .drop_cnt(drop_cnt), .tx_err(tx_err)
   );

   // Bus of DRVS endpoints, port i has ID i.
   logic          b_reset;
   logic          b_pndng[DRVS], b_pop[DRVS], b_push[DRVS], b_wr_en[DRVS];
   logic          b_rd_en[DRVS], b_tx_full[DRVS], b_rx_empty[DRVS], b_tx_err[DRVS];
   logic [W-1:0]  b_dpop[DRVS], b_dpush[DRVS], b_wr_data[DRVS], b_rd_data[DRVS];
   logic [15:0]   b_drop[DRVS];

   for (genvar g = 0; g < DRVS; g++) begin : g_port
      drvr_fifo_endpoint #(.width(W), .depth(D), .my_id(8'(g))) u_ep (
         .clk(clk), .reset(b_reset), .pndng(b_pndng[g]), .D_pop(b_dpop[g]),
         .pop(b_pop[g]), .push(b_push[g]), .D_push(b_dpush[g]),
         .wr_en(b_wr_en[g]), .wr_data(b_wr_data[g]), .tx_full(b_tx_full[g]),
         .rd_en(b_rd_en[g]), .rd_data(b_rd_data[g]), .rx_empty(b_rx_empty[g]),
         .drop_cnt(b_drop[g]), .tx_err(b_tx_err[g])
      );
   end

   // Drive one cycle of inputs, take the edge, and advance the reference model.
   task automatic apply(input bit rst, input bit we, input logic [W-1:0] wd,
                        input bit pp, input bit ps, input logic [W-1:0] pd,
                        input bit re);
      bit tx_emp, tx_ful, rx_ful, acc;
      reset = rst; wr_en = we; wr_data = wd; pop = pp;
      push = ps; d_push = pd; rd_en = re;
      @(posedge clk);
      #1;
      if (rst) begin
         m_tx.delete(); m_rx.delete(); m_drop = 0; m_err = 0;
      end else begin
         tx_emp = (m_tx.size() == 0);
         tx_ful = (m_tx.size() == D);
         m_err  = (we && tx_ful && !pp) || (pp && tx_emp);
         if (pp && !tx_emp) void'(m_tx.pop_front());
         if (we && (!tx_ful || pp)) m_tx.push_back(wd);
         acc    = ps && ((pd[W-1 -: 8] == MY_ID) || (pd[W-1 -: 8] == 8'hFF));
         rx_ful = (m_rx.size() == D);
         if (re && m_rx.size() > 0) void'(m_rx.pop_front());
         if (acc) begin
            if (!rx_ful || re) m_rx.push_back(pd);
            else if (m_drop < 65535) m_drop++;
         end
      end
      reset = 0; wr_en = 0; pop = 0; push = 0; rd_en = 0;
   endtask

   task automatic idle();
      apply(0, 0, '0, 0, 0, '0, 0);
   endtask

   task automatic test_reset();
      apply(1, 0, '0, 0, 0, '0, 0);
      apply(1, 0, '0, 0, 0, '0, 0);
      for (int i = 0; i < 10; i++) begin
         idle();
         checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL reset_idle_pndng cyc %0d got %b exp 0", i, pndng); end
         checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_idle_rx_empty cyc %0d got %b exp 1", i, rx_empty); end
         checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_idle_drop cyc %0d got %0d exp 0", i, drop_cnt); end
      end
      for (int i = 0; i < 3; i++) apply(0, 1, W'(16'h0100 + i), 0, 1, 16'h0300 + W'(i), 0);
      checks++; if (pndng !== 1'b1) begin errors++; $display("FAIL reset_pre_pndng got %b exp 1", pndng); end
      checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL reset_pre_rx_empty got %b exp 0", rx_empty); end
      apply(1, 1, 16'h0AAA, 1, 1, 16'h03BB, 1);
      checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL reset_mid_pndng got %b exp 0", pndng); end
      checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_full got %b exp 0", tx_full); end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_mid_rx_empty got %b exp 1", rx_empty); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid_drop got %0d exp 0", drop_cnt); end
      checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_err got %b exp 0", tx_err); end
   endtask

   task automatic test_tx_order();
      logic [W-1:0] exp_w [3];
      exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033;
      for (int i = 0; i < 3; i++) apply(0, 1, exp_w[i], 0, 0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (pndng !== 1'b1) begin errors++; $display("FAIL tx_order_pndng idx %0d got %b exp 1", i, pndng); end
         checks++; if (d_pop !== exp_w[i]) begin errors++; $display("FAIL tx_order_data idx %0d got %h exp %h", i, d_pop, exp_w[i]); end
         apply(0, 0, '0, 1, 0, '0, 0);
      end
      checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL tx_order_drained got %b exp 0", pndng); end
   endtask

   task automatic test_tx_full();
      apply(1, 0, '0, 0, 0, '0, 0);
      for (int i = 0; i < D; i++) apply(0, 1, W'($urandom), 0, 0, '0, 0);
      checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full_flag got %b exp 1", tx_full); end
      apply(0, 1, 16'hDEAD, 0, 0, '0, 0);
      checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tx_full_err_pulse got %b exp 1", tx_err); end
      idle();
      checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL tx_full_err_one_cycle got %b exp 0", tx_err); end
      apply(0, 1, 16'hBEEF, 1, 0, '0, 0);
      checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full_wr_pop_flag got %b exp 1", tx_full); end
      checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL tx_full_wr_pop_err got %b exp 0", tx_err); end
      for (int i = 0; i < D; i++) begin
         checks++; if (d_pop !== m_tx[0]) begin errors++; $display("FAIL tx_full_drain idx %0d got %h exp %h", i, d_pop, m_tx[0]); end
         if (i == D - 1) begin
            checks++; if (d_pop !== 16'hBEEF) begin errors++; $display("FAIL tx_full_tail got %h exp beef", d_pop); end
         end
         apply(0, 0, '0, 1, 0, '0, 0);
      end
      checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL tx_full_empty_after got %b exp 0", pndng); end
      apply(0, 0, '0, 1, 0, '0, 0);
      checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tx_pop_empty_err got %b exp 1", tx_err); end
      apply(0, 1, 16'h1234, 1, 0, '0, 0);
      checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tx_wr_pop_empty_err got %b exp 1", tx_err); end
      checks++; if (pndng !== 1'b1 || d_pop !== 16'h1234) begin errors++; $display("FAIL tx_wr_pop_empty_data got %b/%h exp 1/1234", pndng, d_pop); end
   endtask

   task automatic test_rx_filter();
      apply(1, 0, '0, 0, 0, '0, 0);
      apply(0, 0, '0, 0, 1, 16'h0301, 0);
      checks++; if (rx_empty !== 1'b0 || rd_data !== 16'h0301) begin errors++; $display("FAIL rx_own_id got %b/%h exp 0/0301", rx_empty, rd_data); end
      apply(0, 0, '0, 0, 1, 16'h0502, 0);
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rx_other_id_drop got %0d exp 0", drop_cnt); end
      apply(0, 0, '0, 0, 0, '0, 1);
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_other_id_filtered got %b exp 1", rx_empty); end
      apply(0, 0, '0, 0, 1, 16'hFF03, 0);
      checks++; if (rx_empty !== 1'b0 || rd_data !== 16'hFF03) begin errors++; $display("FAIL rx_bcast got %b/%h exp 0/ff03", rx_empty, rd_data); end
      apply(0, 0, '0, 0, 0, '0, 1);
      apply(0, 0, '0, 0, 0, '0, 1);
      checks++; if (rx_empty !== 1'b1 || tx_err !== 1'b0) begin errors++; $display("FAIL rx_rd_empty got %b/%b exp 1/0", rx_empty, tx_err); end
   endtask

   task automatic test_rx_overflow();
      apply(1, 0, '0, 0, 0, '0, 0);
      for (int i = 0; i < D; i++) apply(0, 0, '0, 0, 1, {MY_ID, 8'(i)}, 0);
      apply(0, 0, '0, 0, 1, 16'h03A0, 0);
      apply(0, 0, '0, 0, 1, 16'hFFA1, 0);
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL rx_ovf_drop got %0d exp 2", drop_cnt); end
      apply(0, 0, '0, 0, 1, 16'h03A2, 1);
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL rx_ovf_push_rd got %0d exp 2", drop_cnt); end
      apply(0, 0, '0, 0, 1, 16'h03A3, 0);
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL rx_ovf_still_full got %0d exp 3", drop_cnt); end
      for (int i = 0; i < D; i++) begin
         checks++; if (rd_data !== m_rx[0]) begin errors++; $display("FAIL rx_ovf_drain idx %0d got %h exp %h", i, rd_data, m_rx[0]); end
         apply(0, 0, '0, 0, 0, '0, 1);
      end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_ovf_empty_after got %b exp 1", rx_empty); end
   endtask

   task automatic test_random();
      int pw, pp, ps, pr;
      logic [7:0] id;
      apply(1, 0, '0, 0, 0, '0, 0);
      for (int i = 0; i < 800; i++) begin
         case (i / 200)
            0: begin pw = 80; pp = 20; ps = 80; pr = 20; end
            1: begin pw = 50; pp = 50; ps = 50; pr = 50; end
            2: begin pw = 20; pp = 80; ps = 20; pr = 80; end
            default: begin pw = 90; pp = 60; ps = 90; pr = 60; end
         endcase
         case ($urandom_range(2))
            0: id = MY_ID;
            1: id = 8'hFF;
            default: id = 8'($urandom);
         endcase
         apply(0, ($urandom_range(99) < pw), W'($urandom), ($urandom_range(99) < pp),
               ($urandom_range(99) < ps), {id, 8'($urandom)}, ($urandom_range(99) < pr));
         checks++; if (pndng !== (m_tx.size() != 0)) begin errors++; $display("FAIL rand_pndng cyc %0d got %b exp %b", i, pndng, m_tx.size() != 0); end
         checks++; if (tx_full !== (m_tx.size() == D)) begin errors++; $display("FAIL rand_tx_full cyc %0d got %b exp %b", i, tx_full, m_tx.size() == D); end
         checks++; if (rx_empty !== (m_rx.size() == 0)) begin errors++; $display("FAIL rand_rx_empty cyc %0d got %b exp %b", i, rx_empty, m_rx.size() == 0); end
         checks++; if (tx_err !== m_err) begin errors++; $display("FAIL rand_tx_err cyc %0d got %b exp %b", i, tx_err, m_err); end
         checks++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rand_drop cyc %0d got %0d exp %0d", i, drop_cnt, m_drop); end
         if (m_tx.size() != 0) begin
            checks++; if (d_pop !== m_tx[0]) begin errors++; $display("FAIL rand_d_pop cyc %0d got %h exp %h", i, d_pop, m_tx[0]); end
         end
         if (m_rx.size() != 0) begin
            checks++; if (rd_data !== m_rx[0]) begin errors++; $display("FAIL rand_rd_data cyc %0d got %h exp %h", i, rd_data, m_rx[0]); end
         end
      end
   endtask

   task automatic test_bus();
      int  src;
      bit  got;
      b_reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b_reset = 0;
      b_wr_en[0] = 1; b_wr_data[0] = 16'h0512;
      @(posedge clk); #1;
      b_wr_en[0] = 0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         src = -1;
         for (int p = DRVS - 1; p >= 0; p--) if (b_pndng[p]) src = p;
         if (src >= 0) begin
            b_pop[src] = 1;
            for (int p = 0; p < DRVS; p++) begin b_push[p] = 1; b_dpush[p] = b_dpop[src]; end
         end
         @(posedge clk); #1;
         for (int p = 0; p < DRVS; p++) begin b_pop[p] = 0; b_push[p] = 0; end
         if (!b_rx_empty[5]) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL bus_delivery_timeout got rx_empty %b exp 0", b_rx_empty[5]); end
      checks++; if (b_rd_data[5] !== 16'h0512) begin errors++; $display("FAIL bus_port5_data got %h exp 0512", b_rd_data[5]); end
      for (int p = 0; p < DRVS; p++) begin
         if (p != 5) begin
            checks++; if (b_rx_empty[p] !== 1'b1) begin errors++; $display("FAIL bus_other_port %0d rx_empty got %b exp 1", p, b_rx_empty[p]); end
         end
      end
      checks++; if (b_pndng[0] !== 1'b0) begin errors++; $display("FAIL bus_src_drained got %b exp 0", b_pndng[0]); end
   endtask

   initial begin
      reset = 1; pop = 0; push = 0; wr_en = 0; rd_en = 0; d_push = '0; wr_data = '0;
      b_reset = 1;
      for (int p = 0; p < DRVS; p++) begin
         b_pop[p] = 0; b_push[p] = 0; b_wr_en[p] = 0; b_rd_en[p] = 0;
         b_dpush[p] = '0; b_wr_data[p] = '0;
      end
      m_drop = 0; m_err = 0;
      test_reset();
      test_tx_order();
      test_tx_full();
      test_rx_filter();
      test_rx_overflow();
      test_random();
      test_bus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
